// File: rtl/aes_sbox_sched_pkg.sv
// Shared types and constants for the AES S-box scheduler: FSM states, owner
// encoding, request byte counts and the tag carried alongside each S-box issue.
package aes_sbox_sched_pkg;

  localparam int SBOX_INPUT_WIDTH = 8;
  localparam int KEY_BYTES        = 4;
  localparam int DAT_BYTES        = 16;
  localparam int IDX_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic {
    OWN_KEY = 1'b0,
    OWN_DAT = 1'b1
  } owner_t;

  typedef struct packed {
    logic             vld;
    owner_t           owner;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic int issue_count(input int nbytes, input int lanes);
    return (nbytes + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/aes_sbox_scheduler_if.sv
// Request/response channels of the two S-box clients plus the S-box lane bus.
// master = client/S-box side, slave = scheduler side.
interface aes_sbox_scheduler_if #(
  parameter int LANES = 4
);
  import aes_sbox_sched_pkg::*;

  logic                              key_req_vld;
  logic                              key_req_rdy;
  logic [31:0]                       key_req_word;
  logic                              key_rsp_vld;
  logic [31:0]                       key_rsp_word;
  logic                              dat_req_vld;
  logic                              dat_req_rdy;
  logic [127:0]                      dat_req_state;
  logic                              dat_req_inv;
  logic                              dat_rsp_vld;
  logic [127:0]                      dat_rsp_state;
  logic                              sbox_in_vld;
  logic                              sbox_in_inv;
  logic [SBOX_INPUT_WIDTH*LANES-1:0] sbox_in_data;
  logic [SBOX_INPUT_WIDTH*LANES-1:0] sbox_out_data;

  modport master (
    output key_req_vld, key_req_word, dat_req_vld, dat_req_state, dat_req_inv,
           sbox_out_data,
    input  key_req_rdy, key_rsp_vld, key_rsp_word, dat_req_rdy, dat_rsp_vld,
           dat_rsp_state, sbox_in_vld, sbox_in_inv, sbox_in_data
  );

  modport slave (
    input  key_req_vld, key_req_word, dat_req_vld, dat_req_state, dat_req_inv,
           sbox_out_data,
    output key_req_rdy, key_rsp_vld, key_rsp_word, dat_req_rdy, dat_rsp_vld,
           dat_rsp_state, sbox_in_vld, sbox_in_inv, sbox_in_data
  );

endinterface

// File: rtl/aes_sbox_tag_pipe.sv
// Delay line that mirrors the S-box latency so each returning lane group
// arrives together with its owner and issue index.
module aes_sbox_tag_pipe
  import aes_sbox_sched_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t [LAT:0] w_chain;

  assign w_chain[0] = i_tag;

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    tag_t r_tag;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tag <= '0;
      else     r_tag <= w_chain[gi];
    end
    assign w_chain[gi+1] = r_tag;
  end

  assign o_tag = w_chain[LAT];

endmodule

// File: rtl/aes_sbox_scheduler.sv
// Arbitrates whole SubWord/SubBytes requests onto one shared pipelined S-box,
// issues LANES bytes per cycle and reassembles results into response registers.
module aes_sbox_scheduler
  import aes_sbox_sched_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int SBOX_LAT = 3
) (
  input logic                  clk,
  input logic                  rst,
  aes_sbox_scheduler_if.slave  bus
);

  localparam int               LW       = SBOX_INPUT_WIDTH * LANES;
  localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(issue_count(KEY_BYTES, LANES) - 1);
  localparam logic [IDX_W-1:0] DAT_LAST = IDX_W'(issue_count(DAT_BYTES, LANES) - 1);

  state_t           r_state, w_state_next;
  owner_t           r_owner, w_grant;
  logic             r_inv, r_last_key;
  logic [127:0]     r_buf, r_acc, w_acc_next, r_dat_rsp;
  logic [31:0]      r_key_rsp;
  logic             r_key_rsp_vld, r_dat_rsp_vld;
  logic [IDX_W-1:0] r_idx, r_last_idx;
  tag_t             w_tag_in, w_tag_out;
  logic             w_accept, w_issue, w_final;

  // Round-robin: r_last_key clears to 0 so key wins the first contested grant.
  always_comb begin
    w_grant = OWN_KEY;
    if (bus.key_req_vld && bus.dat_req_vld) w_grant = r_last_key ? OWN_DAT : OWN_KEY;
    else if (bus.dat_req_vld)               w_grant = OWN_DAT;
  end

  assign w_accept = (r_state == ST_IDLE) && (bus.key_req_vld || bus.dat_req_vld);
  assign w_issue  = (r_state == ST_ISSUE);
  assign w_final  = w_tag_out.vld &&
                    (w_tag_out.idx == ((w_tag_out.owner == OWN_KEY) ? KEY_LAST : DAT_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
      ST_ISSUE: if (r_idx == r_last_idx) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_final) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.key_req_rdy  = 1'b0;
    bus.dat_req_rdy  = 1'b0;
    bus.sbox_in_vld  = 1'b0;
    bus.sbox_in_inv  = 1'b0;
    bus.sbox_in_data = '0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          bus.key_req_rdy = 1'b1;
          bus.dat_req_rdy = 1'b1;
        end
        ST_ISSUE: begin
          bus.sbox_in_vld  = 1'b1;
          bus.sbox_in_inv  = r_inv;
          bus.sbox_in_data = r_buf[LW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign w_tag_in = '{vld: w_issue, owner: r_owner, idx: r_idx};

  aes_sbox_tag_pipe #(.LAT(SBOX_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Byte gi of the request comes back on lane gi%LANES of issue gi/LANES;
  // key requests never touch bytes above 3 even when lanes are wider.
  for (genvar gi = 0; gi < DAT_BYTES; gi++) begin : g_byte
    localparam int               LANE = gi % LANES;
    localparam logic [IDX_W-1:0] GRP  = IDX_W'(gi / LANES);
    logic w_hit;
    if (gi < KEY_BYTES) begin : g_any
      assign w_hit = w_tag_out.vld && (w_tag_out.idx == GRP);
    end else begin : g_dat
      assign w_hit = w_tag_out.vld && (w_tag_out.idx == GRP) && (w_tag_out.owner == OWN_DAT);
    end
    assign w_acc_next[8*gi +: 8] = w_hit ? bus.sbox_out_data[8*LANE +: 8] : r_acc[8*gi +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner       <= OWN_KEY;
      r_inv         <= 1'b0;
      r_last_key    <= 1'b0;
      r_buf         <= '0;
      r_acc         <= '0;
      r_idx         <= '0;
      r_last_idx    <= '0;
      r_key_rsp     <= '0;
      r_dat_rsp     <= '0;
      r_key_rsp_vld <= 1'b0;
      r_dat_rsp_vld <= 1'b0;
    end else begin
      r_key_rsp_vld <= 1'b0;
      r_dat_rsp_vld <= 1'b0;
      if (w_accept) begin
        r_owner    <= w_grant;
        r_last_key <= (w_grant == OWN_KEY);
        r_idx      <= '0;
        if (w_grant == OWN_KEY) begin
          r_buf      <= {96'b0, bus.key_req_word};
          r_inv      <= 1'b0;
          r_last_idx <= KEY_LAST;
        end else begin
          r_buf      <= bus.dat_req_state;
          r_inv      <= bus.dat_req_inv;
          r_last_idx <= DAT_LAST;
        end
      end else if (w_issue) begin
        r_buf <= r_buf >> LW;
        r_idx <= r_idx + 1'b1;
      end
      if (w_tag_out.vld) r_acc <= w_acc_next;
      // The last lane group is merged on the fly so the response register
      // only changes when a complete result is available.
      if (w_final) begin
        if (w_tag_out.owner == OWN_KEY) begin
          r_key_rsp     <= w_acc_next[31:0];
          r_key_rsp_vld <= 1'b1;
        end else begin
          r_dat_rsp     <= w_acc_next;
          r_dat_rsp_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.key_rsp_vld   = r_key_rsp_vld;
  assign bus.key_rsp_word  = r_key_rsp;
  assign bus.dat_rsp_vld   = r_dat_rsp_vld;
  assign bus.dat_rsp_state = r_dat_rsp;

endmodule

// File: doc/aes_sbox_scheduler.md
# aes_sbox_scheduler

Shares one pipelined composite-field S-box lane group between the AES round datapath (SubBytes, 16 bytes, forward or inverse) and the key-expansion unit (SubWord, 4 bytes, forward only). The scheduler arbitrates whole requests and latches each request's input. It issues `LANES` bytes per cycle into the S-box, which runs GF(256)→GF(16)² map, inversion, inverse map and affine stages. It tracks the fixed S-box latency, reassembles results and returns a one-cycle response pulse to the owner. It sits between the round controller / key scheduler and the S-box instance in the AES IP.

## Interface
Parameters:
- `LANES`, 4, bytes per S-box issue cycle; legal values 1, 2, 4, 8, 16.
- `SBOX_LAT`, 3, cycles from `sbox_in_vld` to matching `sbox_out_data`; must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_req_vld`  in  1  key-expansion SubWord request.
- `key_req_rdy`  out  1  scheduler accepts key request.
- `key_req_word`  in  32  byte i = bits [8i+7:8i].
- `key_rsp_vld`  out  1  one-cycle pulse; `key_rsp_word` valid.
- `key_rsp_word`  out  32  substituted word, same byte order.
- `dat_req_vld`  in  1  round-datapath SubBytes request.
- `dat_req_rdy`  out  1  scheduler accepts data request.
- `dat_req_state`  in  128  byte i = bits [8i+7:8i].
- `dat_req_inv`  in  1  1 = InvSubBytes.
- `dat_rsp_vld`  out  1  one-cycle pulse; `dat_rsp_state` valid.
- `dat_rsp_state`  out  128  substituted state.
- `sbox_in_vld`  out  1  issue strobe to S-box.
- `sbox_in_inv`  out  1  inverse-S-box select for this issue.
- `sbox_in_data`  out  8·LANES  lane j = bits [8j+7:8j].
- `sbox_out_data`  in  8·LANES  S-box result, valid exactly `SBOX_LAT` cycles after the issue.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: `key_req_rdy` = `dat_req_rdy` = 1. On a handshake, latch the payload into the issue buffer, latch the owner and inv flag (key: inv=0), set issue count N = ceil(nbytes/LANES) with nbytes = 4 (key) or 16 (data), then go to ISSUE.
  - ISSUE: one issue per cycle, lowest-numbered bytes first; the buffer shifts down by LANES. Unused upper lanes (key, LANES>4) are driven 0 and their results ignored. After the Nth issue, go to DRAIN.
  - DRAIN: wait for the last result. On capture, pulse the owner's rsp_vld next cycle and return to IDLE.
- Rdy is 0 outside IDLE. Only one request is in flight, and there is no interleaving within a request.
- Arbitration when both vld are high in IDLE: round-robin on a last-grant bit. The requester not granted last wins. After reset, key wins. A single vld is granted immediately.
- Result collection: a `SBOX_LAT`-deep valid/index delay line steers each returning lane group into the result register at byte offset index·LANES.
- The response register holds its value until the next response of the same owner. rsp_vld is a pulse with no backpressure; the owner must capture it.
- Idle drive: `sbox_in_vld`=0, `sbox_in_data`=0, `sbox_in_inv`=0.
- Reset (asserted anytime, including mid-ISSUE/DRAIN):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The delay line and last-grant bit are cleared.
  - In-flight results are discarded and no rsp pulse is produced.
  - rdy outputs are 1 from the first cycle after deassertion.

## Timing
- Handshake accepted in cycle t → first issue in cycle t+1.
- Last issue in cycle t+N. Result capture at the end of cycle t+N+SBOX_LAT. rsp_vld is high in cycle t+N+SBOX_LAT+1.
- Defaults (LANES=4, SBOX_LAT=3): key rsp at t+5; data rsp at t+8.
- rdy returns high in the same cycle as the rsp pulse. A new handshake there issues next cycle, so back-to-back data requests have a throughput of one per N+SBOX_LAT+1 cycles.
- rdy is a pure state decode, with no combinational path from vld.

## Structure
- Package `aes_sbox_sched_pkg`:
  - `SBOX_INPUT_WIDTH`=8;
  - FSM state enum;
  - owner encoding (KEY=0, DAT=1);
  - byte counts 4/16.
- Sub-module `aes_sbox_tag_pipe`: the `SBOX_LAT`-stage shift register of {vld, owner, index}. The top FSM, arbiter, issue buffer and result registers live in `aes_sbox_scheduler`.

## Test plan
- Key request, word 0x00_53_01_FF (byte0=0xFF) with a golden S-box model → issue at t+1; key_rsp at t+5 with word 0x63_ED_7C_16.
- Data request, state bytes 0x00..0x0F, inv=0 → four issues at t+1..t+4. dat_rsp at t+8; byte0=0x63, byte1=0x7C, byte15=0x76.
- Same state with inv=1 → `sbox_in_inv`=1 on all four issues; byte0=0x52, byte1=0x09.
- Both vld high from reset, held → key granted first, data second, then key. Each rsp is a single-cycle pulse, and neither owner is starved.
- `rst` asserted in the cycle of the 2nd data issue → all outputs 0 and no dat_rsp afterward. After release, a fresh key request completes normally at t+5.
- LANES=16 and LANES=1 builds → data takes 1 / 16 issues. rsp at t+5 / t+20 (SBOX_LAT=3) with correct byte order.
